lut3_bist: RTL
==============

LUT3_BIST -- requirements
Module: lut3_bist

Interface
REQ-001 SHALL have parameter INIT, default 8'h83, giving the expected LUT3 truth table; bit k is the expected output for input value k.
REQ-002 SHALL have parameter SETTLE, default 4, giving the cycles to wait after driving a vector before sampling; legal range 1..15.
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port rst_n, input, 1, the reset; asynchronous, active-low.
REQ-005 SHALL have port start, input, 1, a one-cycle pulse that requests a test run.
REQ-006 SHALL have port lut_i, output, 3, which drives the LUT3 under test.
REQ-007 SHALL have port lut_o, input, 1, the output of the LUT3 under test.
REQ-008 SHALL have port busy, output, 1, which is high while a run is in progress.
REQ-009 SHALL have port done, output, 1, which holds high after a run completes until the next start.
REQ-010 SHALL have port pass, output, 1, which is valid while done is high; 1 means no mismatches.
REQ-011 SHALL have port err_count, output, 4, the number of mismatching vectors (0..8).
REQ-012 SHALL have port fail_vec, output, 8, where bit k is set if vector k mismatched.

Function
REQ-013 SHALL implement the FSM states IDLE, DRIVE, WAIT, SAMPLE and DONE.
REQ-014 In IDLE or DONE, when start=1, SHALL clear err_count, fail_vec, pass and done, set the vector index to 0, and go to DRIVE.
REQ-015 In DRIVE, SHALL register lut_i to the vector index, load the wait counter with SETTLE-1, and go to WAIT.
REQ-016 In WAIT, SHALL decrement the counter each cycle and go to SAMPLE when the counter equals 0.
REQ-017 The first lut_i change to the lut_o sample SHALL take exactly SETTLE+1 cycles.
REQ-018 In SAMPLE, if lut_o differs from INIT[index], SHALL set fail_vec[index] and increment err_count.
REQ-019 In SAMPLE, if the index is less than 7, SHALL increment the index and go to DRIVE.
REQ-020 In SAMPLE, if the index equals 7, SHALL go to DONE.
REQ-021 A full run SHALL take 8*(SETTLE+2) cycles from the start-accept edge to done rising; with the default SETTLE this is 48 cycles.
REQ-022 On entering DONE, SHALL set done=1 and busy=0, and set pass=1 only if err_count is 0 (including the final sample).
REQ-023 SHALL ignore start while busy is high.
REQ-024 SHALL treat a start pulse that coincides with the DONE-entry cycle as ignored.
REQ-025 busy SHALL be high in the DRIVE, WAIT and SAMPLE states only.
REQ-026 SHALL hold lut_i at its last driven value in DONE and at 3'b000 in IDLE.
REQ-027 SHALL compare lut_o with the X- or Z-safe identity comparison (===), so an X or Z on lut_o counts as a mismatch.
REQ-028 err_count SHALL saturate at 8 and never wrap.

Reset
REQ-029 When rst_n=0, SHALL asynchronously force state=IDLE and lut_i=0, and clear index, counter, busy, done, pass, err_count and fail_vec.
REQ-030 Reset asserted mid-run SHALL abort the run with no done pulse; after rst_n deasserts, a new start SHALL be required.
REQ-031 Release from reset SHALL be synchronous to clk and SHALL cause no spurious done.

Structure
REQ-032 A shared package lut3_bist_pkg SHALL hold the state enum, VEC_COUNT=8 and the width constants for the counter and index.
REQ-033 A single sub-module, lut3_bist_cnt, SHALL implement the loadable down-counter with a zero flag used by WAIT.
REQ-034 All outputs SHALL be registered, with no combinational path from lut_o to any output.

Verification
REQ-035 Scenario: INIT=8'h83 with a behavioural LUT3 model of 8'h83; pulse start -> done=1 after 48 cycles, pass=1, err_count=0, fail_vec=8'h00.
REQ-036 Scenario: model programmed to 8'h87 -> pass=0, err_count=1, fail_vec=8'h04.
REQ-037 Scenario: lut_o tied to 1'bx -> err_count=8 (saturated), fail_vec=8'hFF, pass=0.
REQ-038 Scenario: start pulsed again at cycle 10 of a run -> run is unaffected and done still rises at cycle 48.
REQ-039 Scenario: rst_n dropped at cycle 20 -> busy=0, done=0 and lut_i=0 immediately; a later start gives a clean 48-cycle run.
REQ-040 Scenario: SETTLE=1 with the model having a 2-cycle delayed output -> mismatches are reported; SETTLE=4 on the same model -> pass=1.

Source files
------------

// File: rtl/lut3_bist_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lut3_bist_pkg -- shared state encoding and widths for the LUT3 BIST. Rev 1.0
// ---------------------------------------------------------------------------
package lut3_bist_pkg;

  localparam int VEC_COUNT = 8;
  localparam int IDX_W     = 3;
  localparam int CNT_W     = 4;
  localparam int ERR_W     = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRIVE  = 3'd1,
    S_WAIT   = 3'd2,
    S_SAMPLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/lut3_bist_cnt.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lut3_bist_cnt -- loadable down-counter with zero flag for settle timing. Rev 1.0
// ---------------------------------------------------------------------------
module lut3_bist_cnt
  import lut3_bist_pkg::*;
#(
  parameter int WIDTH = CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/lut3_bist.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lut3_bist -- drives all 8 LUT3 inputs and compares against INIT. Rev 1.0
// ---------------------------------------------------------------------------
module lut3_bist
  import lut3_bist_pkg::*;
#(
  parameter logic [7:0] INIT   = 8'h83,
  parameter int         SETTLE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [2:0]       lut_i,
  input  logic             lut_o,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [7:0]       fail_vec
);

  state_t           r_state;
  state_t           w_state_next;
  logic [IDX_W-1:0] r_index;
  logic             w_cnt_load;
  logic             w_cnt_dec;
  logic             w_cnt_zero;
  logic             w_last;
  logic             w_mismatch;
  logic [ERR_W-1:0] w_err_inc;
  logic [ERR_W-1:0] w_err_next;

  lut3_bist_cnt #(.WIDTH(CNT_W)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_cnt_load),
    .load_val (CNT_W'(SETTLE - 1)),
    .dec      (w_cnt_dec),
    .zero     (w_cnt_zero)
  );

  assign w_last     = (r_index == IDX_W'(VEC_COUNT - 1));
  // Identity compare so an undriven or floating LUT output is a failure.
  assign w_mismatch = (lut_o !== INIT[r_index]);
  assign w_err_inc  = (err_count == ERR_W'(VEC_COUNT)) ? err_count : err_count + 1'b1;
  assign w_err_next = w_mismatch ? w_err_inc : err_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_load   = 1'b0;
    w_cnt_dec    = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) w_state_next = S_DRIVE;
      end
      S_DRIVE: begin
        w_cnt_load   = 1'b1;
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (w_cnt_zero) w_state_next = S_SAMPLE;
        else            w_cnt_dec    = 1'b1;
      end
      S_SAMPLE: begin
        w_state_next = w_last ? S_DONE : S_DRIVE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_index   <= '0;
      lut_i     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_vec  <= '0;
    end else begin
      busy <= (w_state_next == S_DRIVE) || (w_state_next == S_WAIT) ||
              (w_state_next == S_SAMPLE);
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_index   <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_vec  <= '0;
          end
        end
        S_DRIVE: lut_i <= r_index;
        S_SAMPLE: begin
          err_count <= w_err_next;
          if (w_mismatch) fail_vec[r_index] <= 1'b1;
          if (w_last) begin
            done <= 1'b1;
            pass <= (w_err_next == '0);
          end else begin
            r_index <= r_index + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
